// File: rtl/pipemdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipemdu : iterative 32-bit multiply/divide unit beside the EXE-stage ALU.  |
// | HI/LO architectural registers, 33-cycle shift-add / restoring divide.      |
// | Option: PIPEMDU_SIGNED_EN enables signed mult/div (eop[0]=1).               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipemdu (
  input  logic        clock,
  input  logic        reset,
  input  logic        estart,
  input  logic [1:0]  eop,
  input  logic        ewhi,
  input  logic        ewlo,
  input  logic        erdhilo,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mdu_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [64:0] acc;
  logic [32:0] mag_b;
  logic        is_div;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Multiply: {upper 33, multiplier 32}; add multiplicand on LSB, shift right.
  logic [33:0] mul_sum;
  assign mul_sum = {1'b0, acc[64:32]} + (acc[0] ? {1'b0, mag_b} : 34'd0);

  // Divide: {remainder 33, quotient 32}; shift left, trial-subtract divisor.
  logic [32:0] div_trial;
  logic [33:0] div_diff;
  assign div_trial = acc[63:31];
  assign div_diff  = {1'b0, div_trial} - {1'b0, mag_b};

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  assign prod = acc[63:0];
  assign quo  = acc[31:0];
  assign rem  = acc[63:32];

`ifdef PIPEMDU_SIGNED_EN
  logic        sign_a;
  logic        sign_b;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign sign_a = eop[0] & ea[31];
  assign sign_b = eop[0] & eb[31];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31.
  assign abs_a  = sign_a ? (32'd0 - ea) : ea;
  assign abs_b  = sign_b ? (32'd0 - eb) : eb;

  assign prod_fix = neg_q ? (64'd0 - prod) : prod;
  assign quo_fix  = neg_q ? (32'd0 - quo)  : quo;
  assign rem_fix  = neg_r ? (32'd0 - rem)  : rem;
  assign fix_hi   = is_div ? rem_fix : prod_fix[63:32];
  assign fix_lo   = is_div ? quo_fix : prod_fix[31:0];
`else
  logic unused_op0;
  assign unused_op0 = eop[0];
  assign abs_a  = ea;
  assign abs_b  = eb;
  assign fix_hi = is_div ? rem : prod[63:32];
  assign fix_lo = is_div ? quo : prod[31:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 5'd0;
      acc    <= 65'd0;
      mag_b  <= 33'd0;
      is_div <= 1'b0;
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
`ifdef PIPEMDU_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (estart) begin
            acc    <= {33'd0, abs_a};
            mag_b  <= {1'b0, abs_b};
            is_div <= eop[1];
            count  <= 5'd0;
`ifdef PIPEMDU_SIGNED_EN
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
`endif
            state  <= eop[1] ? DIV : MUL;
          end else begin
            if (ewhi) hi_reg <= ea;
            if (ewlo) lo_reg <= ea;
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[31:1]};
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        DIV: begin
          if (!div_diff[33]) acc <= {div_diff[32:0], acc[30:0], 1'b1};
          else               acc <= {div_trial,      acc[30:0], 1'b0};
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign busy      = (state != IDLE);
  assign mdu_stall = busy & (estart | ewhi | ewlo | erdhilo);

endmodule
`default_nettype wire

// File: tb/tb_pipemdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipemdu : directed self-checking bench for pipemdu.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipemdu;

  logic        clock = 1'b0;
  logic        reset;
  logic        estart;
  logic [1:0]  eop;
  logic        ewhi;
  logic        ewlo;
  logic        erdhilo;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        mdu_stall;

  int checks = 0;
  int errors = 0;

  pipemdu dut (
    .clock     (clock),
    .reset     (reset),
    .estart    (estart),
    .eop       (eop),
    .ewhi      (ewhi),
    .ewlo      (ewlo),
    .erdhilo   (erdhilo),
    .ea        (ea),
    .eb        (eb),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .mdu_stall (mdu_stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one op in the current cycle, count busy cycles, then check HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    estart = 1'b1; eop = op; ea = a; eb = b;
    next_cycle();
    estart = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      next_cycle();
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int n;
    int bad;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    reset = 1'b1; estart = 1'b0; eop = 2'b00; ewhi = 1'b0; ewlo = 1'b0;
    erdhilo = 1'b0; ea = 32'd0; eb = 32'd0;
    next_cycle();
    next_cycle();
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    next_cycle();

    // mthi + mtlo together, then mtlo alone
    ewhi = 1'b1; ewlo = 1'b1; ea = 32'h12345678;
    next_cycle();
    ewhi = 1'b0; ewlo = 1'b0;
    check("mthilo_hi", {32'd0, hi}, 64'h12345678);
    check("mthilo_lo", {32'd0, lo}, 64'h12345678);
    ewlo = 1'b1; ea = 32'h9ABCDEF0;
    next_cycle();
    ewlo = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    check("mtlo_hi_keep", {32'd0, hi}, 64'h12345678);
    erdhilo = 1'b1;
    #1;
    check("idle_no_stall", {63'd0, mdu_stall}, 64'd0);
    erdhilo = 1'b0;

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
`ifdef PIPEMDU_SIGNED_EN
    run_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_neg_d0", 2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001);
`else
    run_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    run_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
    run_op("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_op("div_neg_d0", 2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
`endif
    run_op("divu_5d0", 2'b10, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    run_op("multu_small", 2'b00, 32'd12345, 32'd6789, 32'd0, 32'd83810205);
    run_op("divu_1000d7", 2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);

    // estart held high through a divide: stall every busy cycle, no restart
    prev_hi = hi; prev_lo = lo;
    estart = 1'b1; eop = 2'b10; ea = 32'd100; eb = 32'd7;
    next_cycle();
    eop = 2'b00; ea = 32'd3; eb = 32'd5;
    #1;
    n = 0; bad = 0;
    while (busy && n < 40) begin
      n++;
      if (mdu_stall !== 1'b1) bad++;
      if (n < 33 && (hi !== prev_hi || lo !== prev_lo)) bad++;
      next_cycle();
    end
    check("stall_busy_cycles", 64'(n), 64'd33);
    check("stall_flags", 64'(bad), 64'd0);
    check("stall_release", {63'd0, mdu_stall}, 64'd0);
    check("stall_div_hi", {32'd0, hi}, 64'd2);
    check("stall_div_lo", {32'd0, lo}, 64'd14);
    next_cycle();
    estart = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      next_cycle();
    end
    check("followon_busy_cycles", 64'(n), 64'd33);
    check("followon_hi", {32'd0, hi}, 64'd0);
    check("followon_lo", {32'd0, lo}, 64'd15);

    // asynchronous reset during a multiply, erdhilo stall just before it
    run_op("pre_rst_mul", 2'b00, 32'h00010000, 32'h00010000, 32'd1, 32'd0);
    estart = 1'b1; eop = 2'b00; ea = 32'd9; eb = 32'd9;
    next_cycle();
    estart = 1'b0;
    repeat (9) next_cycle();
    erdhilo = 1'b1;
    #1;
    check("rdhilo_busy_stall", {63'd0, mdu_stall}, 64'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_stall", {63'd0, mdu_stall}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    #1;
    reset = 1'b0;
    erdhilo = 1'b0;
    next_cycle();

    // estart has priority over same-cycle mthi/mtlo
    estart = 1'b1; ewhi = 1'b1; ewlo = 1'b1; eop = 2'b00; ea = 32'h0000DEAD; eb = 32'h10;
    next_cycle();
    estart = 1'b0; ewhi = 1'b0; ewlo = 1'b0;
    check("prio_hi_unwritten", {32'd0, hi}, 64'd0);
    check("prio_lo_unwritten", {32'd0, lo}, 64'd0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      next_cycle();
    end
    check("post_rst_busy_cycles", 64'(n), 64'd33);
    check("post_rst_hi", {32'd0, hi}, 64'd0);
    check("post_rst_lo", {32'd0, lo}, 64'h000DEAD0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
